// File: rtl/mem_pkg.sv
// Shared command encoding and I/O register map for the memory-mapped bus.
package mem_pkg;

  // CPU bus command; the unused encoding 2'b11 behaves like MNONE.
  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  // Word addresses of the I/O registers (RAM occupies 0x000-0x0FF).
  localparam logic [8:0] LEDR_ADDR  = 9'h100;
  localparam logic [8:0] SW_ADDR    = 9'h140;
  localparam logic [8:0] TIMER_ADDR = 9'h180;

  // Target selected by the address decoder.
  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_LEDR,
    REG_SW,
    REG_TIMER
  } region_e;

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM: registered read, write-first on a same-cycle
// read and write to the same word.
module ram_sp #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 256,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage write and registered read port; rdata only moves on a read.
  // NOTE: the array has no reset so it maps onto block RAM; reset of the
  // surrounding logic must never depend on its contents.
  // NOTE: non-blocking assignments keep the read-old/write-new ordering
  // explicit and independent of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      r_rdata <= we ? wdata : r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: RAM, LED register, synchronized switches and a
// free-running timer behind a one-cycle-latency read port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int RAM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(RAM_WORDS - 1);

  logic              r_active;    // low on the edge that releases reset
  logic [7:0]        r_ledr;
  logic [DATA_W-1:0] r_timer;
  logic [7:0]        r_sw_s1;
  logic [7:0]        r_sw_s2;
  logic [DATA_W-1:0] r_rd_data;   // registered non-RAM read result
  logic              r_sel_ram;   // last read targeted RAM

  region_e           w_region;
  logic              w_read;
  logic              w_write;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] w_ram_q;

  // Commands are honoured only once reset has been released for an edge.
  assign w_read  = r_active && (mem_cmd == MREAD);
  assign w_write = r_active && (mem_cmd == MWRITE);

  // Address decode into a single target region.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_region = REG_NONE;
    if (mem_addr <= RAM_LAST) begin
      w_region = REG_RAM;
    end else if (mem_addr == ADDR_W'(LEDR_ADDR)) begin
      w_region = REG_LEDR;
    end else if (mem_addr == ADDR_W'(SW_ADDR)) begin
      w_region = REG_SW;
    end else if (mem_addr == ADDR_W'(TIMER_ADDR)) begin
      w_region = REG_TIMER;
    end
  end

  // Read mux for the register-backed targets; LEDR and holes read as zero.
  always_comb begin
    w_rd_next = '0;
    case (w_region)
      REG_SW:    w_rd_next = DATA_W'(r_sw_s2);
      REG_TIMER: w_rd_next = r_timer;
      default:   w_rd_next = '0;
    endcase
  end

  ram_sp #(
    .DATA_W (DATA_W),
    .WORDS  (RAM_WORDS),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_write && (w_region == REG_RAM)),
    .re    (w_read && (w_region == REG_RAM)),
    .addr  (mem_addr[RAM_AW-1:0]),
    .wdata (write_data),
    .rdata (w_ram_q)
  );

  // Block the command sampled on the reset-release edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ledr <= '0;
    end else if (w_write && (w_region == REG_LEDR)) begin
      r_ledr <= write_data[7:0];
    end
  end

  // Free-running timer; a write loads it in place of that edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_write && (w_region == REG_TIMER)) begin
      r_timer <= write_data;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Read result register; both it and the RAM output hold between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
      r_sel_ram <= 1'b0;
    end else if (w_read) begin
      r_rd_data <= w_rd_next;
      r_sel_ram <= (w_region == REG_RAM);
    end
  end

  assign read_data = r_sel_ram ? w_ram_q : r_rd_data;
  assign LEDR      = r_ledr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard queue of read results.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  SW;
  logic [7:0]  LEDR;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];

  mem_responder #(
    .DATA_W    (16),
    .ADDR_W    (9),
    .RAM_WORDS (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .SW         (SW),
    .LEDR       (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One command cycle: drive after the falling edge, return 1 after rising.
  task automatic cmd_cycle(input logic [1:0] c, input logic [8:0] a,
                           input logic [15:0] d);
    @(negedge clk);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    cmd_cycle(MWRITE, a, d);
  endtask

  task automatic do_idle();
    cmd_cycle(MNONE, 9'h000, 16'h0000);
  endtask

  // Read: expected value enters the scoreboard when the command is driven
  // and is compared against read_data one edge later.
  task automatic do_read(input string tag, input logic [8:0] a,
                         input logic [15:0] e);
    logic [15:0] exp_v;
    @(negedge clk);
    mem_cmd  = MREAD;
    mem_addr = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, read_data, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    mem_cmd    = MNONE;
    mem_addr   = '0;
    write_data = '0;
    SW         = 8'h00;
    #3;
    check("reset_read_data", read_data, 16'h0000);
    check("reset_ledr", {8'h00, LEDR}, 16'h0000);

    // Release reset with a LEDR write pending: that edge must ignore it.
    @(negedge clk);
    mem_cmd    = MWRITE;
    mem_addr   = LEDR_ADDR;
    write_data = 16'h0077;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check("release_edge_ignored", {8'h00, LEDR}, 16'h0000);

    // RAM write then read back; read_data holds afterwards.
    do_write(9'h005, 16'hABCD);
    do_read("ram_rd_005", 9'h005, 16'hABCD);
    do_idle();
    check("hold_after_idle", read_data, 16'hABCD);
    do_write(9'h006, 16'h5555);
    check("hold_during_write", read_data, 16'hABCD);
    do_read("ram_rd_006", 9'h006, 16'h5555);
    do_write(9'h0FF, 16'h1234);
    do_read("ram_rd_top", 9'h0FF, 16'h1234);

    // Held MWRITE rewrites each cycle; last data wins.
    do_write(9'h010, 16'h1111);
    do_write(9'h010, 16'h2222);
    do_write(9'h010, 16'h3333);
    do_read("ram_rewrite", 9'h010, 16'h3333);

    // LEDR write-only register.
    do_write(LEDR_ADDR, 16'h12A5);
    check("ledr_write", {8'h00, LEDR}, 16'h00A5);
    do_read("ledr_rd_zero", LEDR_ADDR, 16'h0000);

    // Switch change lands mid-cycle; a read sampled on the next edge still
    // sees the old value, one issued after the second edge sees the new one.
    @(negedge clk);
    SW       = 8'h3C;
    mem_cmd  = MREAD;
    mem_addr = SW_ADDR;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    check("sw_not_yet", read_data, exp_q.pop_front());
    do_idle();
    do_read("sw_synced", SW_ADDR, 16'h003C);
    do_write(SW_ADDR, 16'h00AA);
    do_read("sw_write_ignored", SW_ADDR, 16'h003C);

    // Timer load, then a held read tracks the count through the wrap.
    do_write(TIMER_ADDR, 16'hFFFE);
    do_read("timer_0", TIMER_ADDR, 16'hFFFE);
    do_read("timer_1", TIMER_ADDR, 16'hFFFF);
    do_read("timer_wrap", TIMER_ADDR, 16'h0000);
    do_write(TIMER_ADDR, 16'h1000);
    do_read("timer_load", TIMER_ADDR, 16'h1000);

    // Unmapped read returns zero; command 11 is a no-op.
    do_read("ram_before_nop", 9'h005, 16'hABCD);
    do_read("unmapped_rd", 9'h1FF, 16'h0000);
    cmd_cycle(2'b11, 9'h005, 16'hDEAD);
    check("cmd11_hold", read_data, 16'h0000);
    do_write(9'h1FF, 16'hBEEF);
    do_read("ram5_unaltered", 9'h005, 16'hABCD);
    do_read("unmapped_after_wr", 9'h1FF, 16'h0000);

    // Asynchronous reset pulse between edges with LEDR lit and timer running.
    do_write(LEDR_ADDR, 16'h00FF);
    check("ledr_ff", {8'h00, LEDR}, 16'h00FF);
    do_read("pre_reset_rd", 9'h005, 16'hABCD);
    @(negedge clk);
    mem_cmd = MNONE;
    #2 reset = 1'b0;
    #1;
    check("async_ledr", {8'h00, LEDR}, 16'h0000);
    check("async_read_data", read_data, 16'h0000);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    // Timer restarted at 0 and has counted the release edge.
    do_read("timer_after_reset", TIMER_ADDR, 16'h0001);
    do_read("ram_survives_reset", 9'h005, 16'hABCD);
    check("ledr_after_reset", {8'h00, LEDR}, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-002 The module SHALL have parameter ADDR_W, default 9, meaning the word-address width.
REQ-003 The module SHALL have parameter RAM_WORDS, default 256, meaning the RAM depth mapped at address 0.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1; reset is asynchronous and active-low (asserted at 0).
REQ-006 The module SHALL have port mem_cmd, input, 2, the command from the CPU.
REQ-007 The module SHALL have port mem_addr, input, ADDR_W, the word address.
REQ-008 The module SHALL have port write_data, input, DATA_W, the store data.
REQ-009 The module SHALL have port read_data, output, DATA_W, the registered load data.
REQ-010 The module SHALL have port SW, input, 8, the asynchronous switch inputs.
REQ-011 The module SHALL have port LEDR, output, 8, the LED output register.

Function
REQ-012 mem_cmd SHALL be decoded as MNONE=00, MREAD=01, MWRITE=10; 11 SHALL be treated as MNONE.
REQ-013 The address map SHALL be: 0x000-0x0FF RAM; 0x100 LEDR (write); 0x140 SW (read); 0x180 TIMER (read/write); all other addresses unmapped.
REQ-014 MREAD SHALL have one-cycle latency: read_data updates at the first rising edge after mem_cmd=MREAD is sampled.
REQ-015 While mem_cmd is not MREAD, read_data SHALL hold its last value.
REQ-016 An MREAD to RAM SHALL return the word stored at mem_addr[7:0].
REQ-017 An MREAD to SW SHALL return {8'h00, sw_sync}.
REQ-018 An MREAD to TIMER SHALL return the TIMER value before that edge's update.
REQ-019 An MREAD to LEDR or to an unmapped address SHALL return 16'h0000.
REQ-020 MWRITE SHALL commit at the sampling edge: to RAM at mem_addr[7:0], to LEDR using write_data[7:0], or to TIMER using write_data.
REQ-021 MWRITE to SW or an unmapped address SHALL be ignored.
REQ-022 An MREAD to an address in the cycle after an MWRITE to that address SHALL return the newly written data.
REQ-023 mem_cmd held at MREAD for N consecutive cycles SHALL re-read every cycle; for RAM the value is stable, for TIMER it tracks the count.
REQ-024 mem_cmd held at MWRITE for multiple cycles SHALL rewrite each cycle with no other side effect.
REQ-025 sw_sync SHALL be SW passed through a two-flop synchronizer, so a SW change is visible to a read sampled two edges later.
REQ-026 TIMER SHALL increment by 1 every cycle and wrap from 16'hFFFF to 16'h0000.
REQ-027 An MWRITE to TIMER SHALL take priority over the increment on that edge; TIMER SHALL resume counting from the loaded value on the next edge.

Reset
REQ-028 Assertion of reset SHALL immediately set read_data=0, LEDR=0, TIMER=0, and both synchronizer stages=0, without waiting for clk.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 A command sampled at the same edge at which reset is released SHALL be ignored.
REQ-031 A write in progress when reset asserts SHALL have no guaranteed effect on RAM.

Structure
REQ-032 Package mem_pkg SHALL hold the MNONE/MREAD/MWRITE constants and the LEDR_ADDR, SW_ADDR, and TIMER_ADDR constants; the CPU FSM and this block SHALL both import it.
REQ-033 RAM storage SHALL be one sub-module, ram_sp: a synchronous single-port RAM of RAM_WORDS x DATA_W with a write-enable, one-cycle registered read, and write-first behaviour.
REQ-034 Address decode, LEDR, TIMER, the synchronizer, and the read_data mux/register SHALL reside in mem_responder.

Verification
REQ-035 Bench: MWRITE 0x005 data 16'hABCD, then MREAD 0x005 -> read_data=16'hABCD one edge after the read.
REQ-036 Bench: MWRITE 0x100 data 16'h12A5 -> LEDR=8'hA5; then MREAD 0x100 -> read_data=16'h0000.
REQ-037 Bench: SW=8'h3C set mid-cycle, MREAD 0x140 issued at the second following edge -> read_data=16'h003C.
REQ-038 Bench: MWRITE 0x180 data 16'hFFFE, then MREAD 0x180 for 3 cycles -> read_data sequence 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-039 Bench: MREAD 0x1FF and mem_cmd=11 to 0x005 -> read_data=16'h0000 for the first, then unchanged; RAM[5] unaltered.
REQ-040 Bench: reset pulsed low between edges with LEDR=8'hFF and TIMER running -> LEDR, read_data, and TIMER all 0 immediately; RAM[5] still 16'hABCD.
